// File: rtl/mem_ctrl_if.sv
// Bundle of the client request/response signals and the 8-bit memory bus
// seen by mem_ctrl; master is the controller's view, slave the environment's.
interface mem_ctrl_if;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_valid;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  modport master (
    input  rdy_in, mem_din, io_buffer_full, flush,
    input  if_valid, if_addr,
    input  ls_valid, ls_wr, ls_size, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data, ls_done, ls_rdata
  );

  modport slave (
    output rdy_in, mem_din, io_buffer_full, flush,
    output if_valid, if_addr,
    output ls_valid, ls_wr, ls_size, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data, ls_done, ls_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store clients and
// splits their 1/2/4-byte accesses into single-byte cycles on the 8-bit bus.
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic       clk_in,
  input  logic       rst_in,
  mem_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic        owner_ls;
  logic [1:0]  n_last;
  logic [1:0]  idx;
  logic        issued_all;
  logic        cap_valid;
  logic [1:0]  cap_idx;
  logic [31:0] rbuf, rbuf_nx;
  logic [23:0] wbuf;
  logic        accept, issue, io_block, final_cap;

  function automatic logic [1:0] size_last(input logic [1:0] sz);
    case (sz)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // A read byte lands on mem_din one cycle after it was issued, so the capture
  // slot trails the issue slot and completion is decided by the capture side.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    issue     = 1'b0;
    io_block  = 1'b0;
    final_cap = 1'b0;
    rbuf_nx   = rbuf;
    if (cap_valid) rbuf_nx[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    case (state)
      IDLE: begin
        if (bus.rdy_in && !bus.flush && (bus.if_valid || bus.ls_valid)) begin
          accept   = 1'b1;
          state_nx = (bus.ls_valid && bus.ls_wr) ? WRITE : READ;
        end
      end
      READ: begin
        issue     = bus.rdy_in && !issued_all;
        final_cap = cap_valid && (cap_idx == n_last);
        if (bus.flush)      state_nx = IDLE;
        else if (final_cap) state_nx = DONE;
      end
      WRITE: begin
        io_block = (bus.mem_a[17:16] == IO_HI) && bus.io_buffer_full;
        issue    = bus.rdy_in && !io_block;
        if (issue && (idx == n_last)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_wr  = (state == WRITE) && issue;
  assign bus.if_done = (state == DONE) && !owner_ls;
  assign bus.ls_done = (state == DONE) && owner_ls;

  // Address and write byte only advance on an issued byte, so a stall or a
  // blocked IO write simply keeps presenting the same byte.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.mem_a    <= '0;
      bus.mem_dout <= '0;
      bus.if_data  <= '0;
      bus.ls_rdata <= '0;
      owner_ls     <= 1'b0;
      n_last       <= '0;
      idx          <= '0;
      issued_all   <= 1'b0;
      cap_valid    <= 1'b0;
      cap_idx      <= '0;
      rbuf         <= '0;
      wbuf         <= '0;
    end else begin
      cap_valid <= (state == READ) && issue && !bus.flush;
      cap_idx   <= idx;
      if (accept) begin
        owner_ls   <= bus.ls_valid;
        bus.mem_a  <= bus.ls_valid ? bus.ls_addr : bus.if_addr;
        n_last     <= bus.ls_valid ? size_last(bus.ls_size) : 2'd3;
        idx        <= '0;
        issued_all <= 1'b0;
        rbuf       <= '0;
        if (bus.ls_valid && bus.ls_wr) begin
          bus.mem_dout <= bus.ls_wdata[7:0];
          wbuf         <= bus.ls_wdata[31:8];
        end
      end
      if (issue) begin
        if (idx == n_last) begin
          issued_all <= 1'b1;
        end else begin
          idx       <= idx + 2'd1;
          bus.mem_a <= bus.mem_a + 32'd1;
          if (state == WRITE) begin
            bus.mem_dout <= wbuf[7:0];
            wbuf         <= {8'h00, wbuf[23:8]};
          end
        end
      end
      if (state == READ) rbuf <= rbuf_nx;
      if (final_cap && !bus.flush) begin
        if (owner_ls) bus.ls_rdata <= rbuf_nx;
        else          bus.if_data  <= rbuf_nx;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: a byte RAM on the bus plus a transaction-level
// reference that predicts issue cycles, done cycles and returned data.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram       [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];

  // Bus-side RAM with a registered one-cycle read.
  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
    bus.mem_din <= rd;
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end

  int          rdy_pct, io_pct, io_hold, stall_start, stall_len, flush_off, pre_hold;
  logic        keep_if;
  logic [31:0] keep_if_addr;
  int          last_done_o;
  logic        aborted;
  logic [31:0] exp_if, exp_ls;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] modelRd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] base, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = modelRd(base + 32'(i));
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]       = d;
    model_mem[a] = d;
  endtask

  task automatic resetKnobs();
    rdy_pct = 100; io_pct = 0; io_hold = 0; stall_start = 0; stall_len = 0;
    flush_off = -1; pre_hold = 0; keep_if = 1'b0; keep_if_addr = '0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_wr"}, 32'(bus.mem_wr), 32'd0);
    checkOutput({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
    checkOutput({tag, "_ls_done"}, 32'(bus.ls_done), 32'd0);
    checkOutput({tag, "_if_data"}, bus.if_data, exp_if);
    checkOutput({tag, "_ls_rdata"}, bus.ls_rdata, exp_ls);
  endtask

  task automatic dropRequests();
    bus.if_valid = 1'b0;
    bus.ls_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic driveReq(input int kind, input logic [31:0] base, input logic [1:0] size,
                          input logic [31:0] wdata);
    if (kind == 0) begin
      bus.if_valid = 1'b1;
      bus.if_addr  = base;
      bus.ls_valid = 1'b0;
    end else begin
      bus.ls_valid = 1'b1;
      bus.ls_wr    = (kind == 2);
      bus.ls_size  = size;
      bus.ls_addr  = base;
      bus.ls_wdata = wdata;
      bus.if_valid = keep_if;
      bus.if_addr  = keep_if_addr;
    end
  endtask

  // kind: 0 = fetch, 1 = load, 2 = store. Offsets o count cycles after acceptance.
  task automatic applyStimulus(input int kind, input logic [31:0] base, input logic [1:0] size,
                               input logic [31:0] wdata);
    int          n, k, bi, last_o;
    logic        rdy, iof, fl, issue_now, exp_done, finished;
    logic [31:0] a;
    n        = (kind == 0) ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    k        = 0;
    last_o   = -10;
    aborted  = 1'b0;
    finished = 1'b0;
    exp_done = 1'b0;
    last_done_o = -1;
    for (int p = 0; p < pre_hold; p++) begin
      @(posedge clk); #1;
      driveReq(kind, base, size, wdata);
      bus.io_buffer_full = 1'b0;
      if (p % 2 == 0) begin
        bus.rdy_in = 1'b0;
        bus.flush  = 1'($urandom_range(0, 1));
      end else begin
        bus.rdy_in = 1'($urandom_range(0, 1));
        bus.flush  = 1'b1;
      end
      @(negedge clk);
      checkIdle("prehold");
    end
    @(posedge clk); #1;
    driveReq(kind, base, size, wdata);
    bus.rdy_in         = 1'b1;
    bus.flush          = 1'b0;
    bus.io_buffer_full = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkIdle("accept");
    for (int o = 1; o <= 120; o++) begin
      @(posedge clk); #1;
      if (o >= stall_start && o < stall_start + stall_len) rdy = 1'b0;
      else rdy = (int'($urandom_range(1, 100)) <= rdy_pct);
      iof = (o <= io_hold) ? 1'b1 : (int'($urandom_range(1, 100)) <= io_pct);
      a   = base + 32'(k);
      bi  = k;
      issue_now = 1'b0;
      exp_done  = 1'b0;
      if (k < n) issue_now = rdy && !(kind == 2 && a[17:16] == 2'b11 && iof);
      if (issue_now) begin
        k++;
        if (k == n) last_o = o;
      end else if (k == n) begin
        exp_done = (o == last_o + ((kind == 2) ? 1 : 2));
      end
      fl = (o == flush_off);
      bus.rdy_in         = rdy;
      bus.io_buffer_full = iof;
      bus.flush          = fl;
      @(negedge clk);
      checkOutput("mem_wr", 32'(bus.mem_wr), 32'(issue_now && kind == 2));
      if (issue_now) begin
        checkOutput("mem_a", bus.mem_a, a);
        if (kind == 2) begin
          checkOutput("mem_dout", 32'(bus.mem_dout), 32'(wdata[8*bi +: 8]));
          model_mem[a] = wdata[8*bi +: 8];
        end
      end
      if (exp_done && kind == 0) exp_if = modelLoad(base, 4);
      if (exp_done && kind == 1) exp_ls = modelLoad(base, n);
      checkOutput("if_done", 32'(bus.if_done), 32'(exp_done && kind == 0));
      checkOutput("ls_done", 32'(bus.ls_done), 32'(exp_done && kind != 0));
      checkOutput("if_data", bus.if_data, exp_if);
      checkOutput("ls_rdata", bus.ls_rdata, exp_ls);
      if (exp_done) begin
        last_done_o = o;
        finished    = 1'b1;
        break;
      end
      if (fl && kind != 2) begin
        aborted  = 1'b1;
        finished = 1'b1;
        break;
      end
    end
    checkOutput("timeout", 32'(finished), 32'd1);
    if (aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        dropRequests();
        bus.rdy_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkIdle("after_flush");
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dropRequests();
      bus.rdy_in = 1'b1;
      @(negedge clk);
      checkIdle("idle");
    end
  endtask

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 4))
      0:       return 32'h100 + 32'($urandom_range(0, 60));
      1:       return 32'h2000 + 32'($urandom_range(0, 15));
      2:       return 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      3:       return 32'h0002FFFE + 32'($urandom_range(0, 3));
      default: return 32'h0003FFFE + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    int kind, n;
    logic [1:0] sz;
    checks = 0; failures = 0;
    exp_if = '0; exp_ls = '0;
    resetKnobs();
    rst = 1'b1;
    bus.rdy_in = 1'b0; bus.io_buffer_full = 1'b0; bus.flush = 1'b0;
    bus.if_valid = 1'b0; bus.if_addr = '0;
    bus.ls_valid = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = '0;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    for (int i = 0; i < 64; i++) preload(32'h100 + 32'(i), 8'($urandom));
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    for (int i = 0; i < 8; i++) begin
      preload(32'hFFFFFFFC + 32'(i), 8'($urandom));
      preload(32'h0002FFFC + 32'(i), 8'($urandom));
      preload(32'h0003FFFC + 32'(i), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_mem_a", bus.mem_a, 32'h0);
    checkOutput("reset_mem_dout", 32'(bus.mem_dout), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rdy_in = 1'b1;

    applyStimulus(0, 32'h100, 2'd2, 32'h0);
    checkOutput("fetch_data", bus.if_data, 32'h00000513);
    checkOutput("fetch_cycle", 32'(last_done_o), 32'd6);

    applyStimulus(2, 32'h2002, 2'd1, 32'hA1B2C3D4);
    checkOutput("store_half_cycle", 32'(last_done_o), 32'd3);
    applyStimulus(1, 32'h2003, 2'd0, 32'h0);
    checkOutput("load_c3", bus.ls_rdata, 32'h000000C3);

    keep_if = 1'b1; keep_if_addr = 32'h108;
    applyStimulus(1, 32'h2000, 2'd2, 32'h0);
    keep_if = 1'b0;
    applyStimulus(0, 32'h108, 2'd2, 32'h0);
    checkOutput("prio_if_cycle", 32'(last_done_o), 32'd6);

    stall_start = 3; stall_len = 3;
    applyStimulus(1, 32'h104, 2'd2, 32'h0);
    checkOutput("stall_cycle", 32'(last_done_o), 32'd9);
    resetKnobs();

    io_hold = 5;
    applyStimulus(2, 32'h00030000, 2'd0, 32'h00000041);
    checkOutput("io_cycle", 32'(last_done_o), 32'd7);
    resetKnobs();

    flush_off = 3;
    applyStimulus(0, 32'h110, 2'd2, 32'h0);
    checkOutput("fetch_flushed", 32'(aborted), 32'd1);
    flush_off = 2;
    applyStimulus(2, 32'h2008, 2'd2, 32'hCAFEF00D);
    checkOutput("store_flush_cycle", 32'(last_done_o), 32'd5);
    resetKnobs();
    applyStimulus(1, 32'h2008, 2'd2, 32'h0);
    checkOutput("store_flush_data", bus.ls_rdata, 32'hCAFEF00D);

    applyStimulus(1, 32'hFFFFFFFE, 2'd2, 32'h0);
    pre_hold = 4;
    applyStimulus(2, 32'h2005, 2'd0, 32'h0000005A);
    resetKnobs();

    // Reset in the middle of a word store leaves the first two bytes written.
    @(posedge clk); #1;
    bus.ls_valid = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h80; bus.ls_wdata = 32'h11223344; bus.if_valid = 1'b0;
    bus.rdy_in = 1'b1; bus.io_buffer_full = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_wr", 32'(bus.mem_wr), 32'd1);
      checkOutput("rst_a", bus.mem_a, 32'h80 + 32'(i));
      model_mem[32'h80 + 32'(i)] = (i == 0) ? 8'h44 : 8'h33;
    end
    @(posedge clk); #1;
    bus.rdy_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_stall_wr", 32'(bus.mem_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dropRequests(); bus.rdy_in = 1'b1;
    exp_if = '0; exp_ls = '0;
    @(negedge clk);
    checkIdle("midreset");
    checkOutput("midreset_mem_a", bus.mem_a, 32'h0);
    applyStimulus(1, 32'h80, 2'd2, 32'h0);
    checkOutput("partial_write", bus.ls_rdata, 32'h00003344);

    for (int t = 0; t < 70; t++) begin
      resetKnobs();
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 2));
      n    = (kind == 0) ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      rdy_pct  = int'($urandom_range(60, 100));
      io_pct   = 50;
      pre_hold = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) flush_off = int'($urandom_range(1, n + 1));
      applyStimulus(kind, pickAddr(), sz, $urandom);
      if ($urandom_range(0, 3) == 0) idleCycles(1);
    end

    idleCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller inside the CPU; the stage directly upstream of the top-level 8-bit memory/IO bus.
- Arbitrates two clients, instruction fetch (IF) and load/store (LS), and splits 1/2/4-byte accesses into single-byte bus cycles.
- Honours the bus pause (`rdy_in`), IO back-pressure (`io_buffer_full`) and pipeline flush.
- Bus contract: 1-cycle registered read latency. A byte addressed in cycle t returns on `mem_din` in cycle t+1.

Parameters:
- IO_HI, 2'b11, value of `mem_a[17:16]` that marks the IO region; used for the `io_buffer_full` gating.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  bus granted; low = paused
- mem_din  in  8  read byte from the bus
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write sink full
- flush  in  1  pipeline flush
- if_valid  in  1  fetch request
- if_addr  in  32  fetch address; always a 4-byte access
- if_done  out  1  1-cycle pulse, `if_data` valid
- if_data  out  32  fetched word
- ls_valid  in  1  load/store request
- ls_wr  in  1  1 = store
- ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is illegal)
- ls_addr  in  32  address
- ls_wdata  in  32  store data (low bytes used)
- ls_done  out  1  1-cycle pulse
- ls_rdata  out  32  load data, zero-extended

Behaviour:
- Reset: all outputs 0; state IDLE; byte counters 0.
- States:
  - IDLE: accept a request.
  - READ: issue address bytes and capture returned bytes.
  - WRITE: issue write bytes.
  - DONE: pulse the client's done signal for one cycle, then return to IDLE.
- Acceptance (IDLE, `rdy_in` = 1, `flush` = 0):
  - If `ls_valid`, LS wins; otherwise IF.
  - Latch address, size (N = 1/2/4 bytes), wr flag, wdata and owner.
  - Move to READ or WRITE.
- Request inputs are ignored outside IDLE.
- Client handshake:
  - The client holds valid and its fields stable until done.
  - The client drops valid in the cycle after done.
  - No new request is accepted in the done cycle.
- Byte order: little-endian. Byte k uses address `base + k`, 32-bit wrap-around (0xFFFFFFFF + 1 = 0).
- Issue rule: a byte counts as issued only in a cycle where `rdy_in` = 1. While `rdy_in` = 0:
  - `mem_wr` is forced to 0 combinationally.
  - The issue index and address hold.
- READ timing (acceptance in cycle T, no stalls):
  - `mem_a` = `base + k` in cycle T+1+k.
  - Byte captured from `mem_din` in cycle T+2+k, but only if that byte was issued in T+1+k.
  - The capture happens regardless of `rdy_in` in the capture cycle.
  - Done pulse in cycle T+2+N with data registered; word read returns at T+6.
- No address is ever issued twice, so IO reads are not repeated.
- WRITE timing:
  - `mem_a` / `mem_dout` / `mem_wr` = 1 for byte k in cycle T+1+k.
  - Done pulse in T+1+N.
  - If the current address has `mem_a[17:16]` == IO_HI and `io_buffer_full` = 1, that byte is not issued: `mem_wr` = 0, hold.
- Idle bus: `mem_wr` = 0. `mem_a` and `mem_dout` hold their last values.
- Flush (sampled every cycle):
  - Aborts any IF access and any LS read in progress: next state IDLE, no done pulse, captured bytes discarded.
  - An LS write in progress completes (stores are committed) and still pulses `ls_done`.
  - In IDLE, requests presented in the flush cycle are not accepted.
- Simultaneous `flush` and a done-producing capture: flush wins for reads, so no done pulse.
- Reset mid-operation: immediate return to IDLE. Any partial write stays partial.
- Data outputs `if_data` / `ls_rdata` hold until the next done. Unused upper bytes are 0.

Test Plan:
- Fetch: `if_valid`, `if_addr` = 0x100, RAM bytes 13 05 00 00 → addresses 0x100–0x103 in T+1..T+4; `if_done` at T+6; `if_data` = 0x00000513.
- Store half: `ls_wr` = 1, size 1, addr 0x2002, wdata 0xA1B2C3D4 → writes D4@0x2002 and C3@0x2003, `mem_wr` = 1 for 2 cycles; `ls_done` at T+3. Then a byte load at 0x2003 returns 0x000000C3.
- Priority: `if_valid` and `ls_valid` in the same cycle → LS served first, then IF accepted in the cycle after `ls_done` + 1.
- Stall: `rdy_in` low during byte 2 of a word read for 3 cycles → `mem_wr` = 0, no re-issue, correct word, done delayed by exactly 3 cycles.
- IO: store byte 0x41 to 0x30000 with `io_buffer_full` = 1 for 5 cycles → `mem_wr` stays 0, then a single write; `ls_done` one cycle after the write.
- Flush: flush at T+3 of a fetch → no `if_done`, IDLE at T+4. Flush during a word store → all 4 bytes written, `ls_done` pulses.
